// File: rtl/tug_match_controller.sv
// Match sequencer for the tug-of-war game: countdown, play, round-over and match-over
// phases, player-pulse gating, light-field clear and both saturating score counters.
module tug_match_controller #(
  parameter int STEP_CYCLES = 4,
  parameter int COUNT_STEPS = 3,
  parameter int HOLD_CYCLES = 5,
  parameter int WIN_SCORE   = 7
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic       left_press,
  input  logic       right_press,
  input  logic       victory_left,
  input  logic       victory_right,
  output logic       field_reset,
  output logic       play_en,
  output logic [1:0] countdown,
  output logic [2:0] score_left,
  output logic [2:0] score_right,
  output logic       round_done,
  output logic [1:0] match_winner,
  output logic [2:0] state
);

  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'(STEP_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [1:0]        FIRST_DIGIT = 2'(COUNT_STEPS);
  localparam logic [2:0]        WIN         = 3'(WIN_SCORE);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_COUNTDOWN  = 3'd1,
    ST_PLAY       = 3'd2,
    ST_ROUND_OVER = 3'd3,
    ST_MATCH_OVER = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [1:0]        digit_r, digit_s;
  logic [STEP_W-1:0] step_r, step_s;
  logic [HOLD_W-1:0] hold_r, hold_s;
  logic [2:0]        score_left_r, score_left_s;
  logic [2:0]        score_right_r, score_right_s;
  logic              round_done_r, round_done_s;
  logic [1:0]        winner_r, winner_s;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    if (v == 3'd7) begin
      sat_inc = 3'd7;
    end else begin
      sat_inc = v + 3'd1;
    end
  endfunction

  // Next-state and next-register computation for the match sequencer.
  always_comb begin
    state_s       = state_r;
    digit_s       = digit_r;
    step_s        = step_r;
    hold_s        = hold_r;
    score_left_s  = score_left_r;
    score_right_s = score_right_r;
    round_done_s  = 1'b0;
    winner_s      = winner_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_COUNTDOWN;
          digit_s = FIRST_DIGIT;
          step_s  = '0;
        end else begin
          digit_s = 2'd0;
        end
      end
      ST_COUNTDOWN: begin
        // False starts outrank the step timer.
        if (left_press && right_press) begin
          digit_s = FIRST_DIGIT;
          step_s  = '0;
        end else if (left_press || right_press) begin
          if (left_press) begin
            score_right_s = sat_inc(score_right_r);
          end else begin
            score_left_s = sat_inc(score_left_r);
          end
          state_s      = ST_ROUND_OVER;
          digit_s      = 2'd0;
          step_s       = '0;
          hold_s       = '0;
          round_done_s = 1'b1;
        end else if (step_r == STEP_LAST) begin
          step_s = '0;
          if (digit_r <= 2'd1) begin
            state_s = ST_PLAY;
            digit_s = 2'd0;
          end else begin
            digit_s = digit_r - 2'd1;
          end
        end else begin
          step_s = step_r + STEP_W'(1);
        end
      end
      ST_PLAY: begin
        if (victory_left || victory_right) begin
          if (victory_left && !victory_right) begin
            score_left_s = sat_inc(score_left_r);
          end else if (victory_right && !victory_left) begin
            score_right_s = sat_inc(score_right_r);
          end else begin
            score_left_s = score_left_r;
          end
          state_s      = ST_ROUND_OVER;
          hold_s       = '0;
          round_done_s = 1'b1;
        end else begin
          state_s = ST_PLAY;
        end
      end
      ST_ROUND_OVER: begin
        if (hold_r == HOLD_LAST) begin
          hold_s = '0;
          if (score_left_r == WIN) begin
            state_s  = ST_MATCH_OVER;
            winner_s = 2'b01;
          end else if (score_right_r == WIN) begin
            state_s  = ST_MATCH_OVER;
            winner_s = 2'b10;
          end else begin
            state_s = ST_COUNTDOWN;
            digit_s = FIRST_DIGIT;
            step_s  = '0;
          end
        end else begin
          hold_s = hold_r + HOLD_W'(1);
        end
      end
      ST_MATCH_OVER: begin
        if (start) begin
          state_s       = ST_COUNTDOWN;
          digit_s       = FIRST_DIGIT;
          step_s        = '0;
          score_left_s  = 3'd0;
          score_right_s = 3'd0;
          winner_s      = 2'b00;
        end else begin
          state_s = ST_MATCH_OVER;
        end
      end
      default: begin
        state_s = ST_IDLE;
        digit_s = 2'd0;
        step_s  = '0;
        hold_s  = '0;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r       <= ST_IDLE;
      digit_r       <= 2'd0;
      step_r        <= '0;
      hold_r        <= '0;
      score_left_r  <= 3'd0;
      score_right_r <= 3'd0;
      round_done_r  <= 1'b0;
      winner_r      <= 2'b00;
    end else begin
      state_r       <= state_s;
      digit_r       <= digit_s;
      step_r        <= step_s;
      hold_r        <= hold_s;
      score_left_r  <= score_left_s;
      score_right_r <= score_right_s;
      round_done_r  <= round_done_s;
      winner_r      <= winner_s;
    end
  end

  assign field_reset  = (state_r != ST_PLAY);
  assign play_en      = (state_r == ST_PLAY);
  assign countdown    = digit_r;
  assign score_left   = score_left_r;
  assign score_right  = score_right_r;
  assign round_done   = round_done_r;
  assign match_winner = winner_r;
  assign state        = state_r;

endmodule

// File: tb/tb_tug_match_controller.sv
// Self-checking bench for tug_match_controller: per-cycle vector table fed through a
// scoreboard queue, plus a hand-written reset-during-play sequence.
module tb_tug_match_controller;

  localparam logic [2:0] S_IDLE = 3'd0, S_CD = 3'd1, S_PLAY = 3'd2, S_RO = 3'd3, S_MO = 3'd4;

  typedef struct packed {
    logic rst, start, lp, rp, vl, vr;
  } in_t;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] cd;
    logic [2:0] sl, sr;
    logic       rd;
    logic [1:0] mw;
    logic       fr, pe;
  } out_t;

  typedef struct packed {
    in_t         i;
    out_t        o;
    logic [63:0] tag;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, lp = 1'b0, rp = 1'b0, vl = 1'b0, vr = 1'b0;
  logic       field_reset, play_en, round_done;
  logic [1:0] countdown, match_winner;
  logic [2:0] score_left, score_right, state;

  int   total = 0;
  int   bad = 0;
  vec_t tbl[$];
  out_t exp_q[$];

  tug_match_controller #(
    .STEP_CYCLES(4), .COUNT_STEPS(3), .HOLD_CYCLES(5), .WIN_SCORE(3)
  ) dut (
    .Clock(clk), .Reset(rst), .start(start),
    .left_press(lp), .right_press(rp),
    .victory_left(vl), .victory_right(vr),
    .field_reset(field_reset), .play_en(play_en), .countdown(countdown),
    .score_left(score_left), .score_right(score_right),
    .round_done(round_done), .match_winner(match_winner), .state(state)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(input logic [2:0] st, input logic [1:0] cd,
                              input logic [2:0] sl, input logic [2:0] sr,
                              input logic rd, input logic [1:0] mw);
    out_t o;
    o.st = st; o.cd = cd; o.sl = sl; o.sr = sr; o.rd = rd; o.mw = mw;
    o.fr = (st != S_PLAY);
    o.pe = (st == S_PLAY);
    return o;
  endfunction

  task automatic add(input logic r, input logic s, input logic l, input logic rr,
                     input logic a, input logic b, input out_t o, input logic [63:0] tag);
    vec_t v;
    v.i.rst = r; v.i.start = s; v.i.lp = l; v.i.rp = rr; v.i.vl = a; v.i.vr = b;
    v.o = o; v.tag = tag;
    tbl.push_back(v);
  endtask

  // 11 more countdown cycles after entry (a stray victory included), then PLAY.
  task automatic cd_tail(input logic [2:0] sl, input logic [2:0] sr);
    for (int k = 1; k <= 11; k++)
      add(1'b0, 1'b0, 1'b0, 1'b0, (k == 2), 1'b0, mk(S_CD, 2'(3 - k / 4), sl, sr, 1'b0, 2'b00), "cd_tail");
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(S_PLAY, 2'd0, sl, sr, 1'b0, 2'b00), "to_play");
  endtask

  // Remaining hold cycles with ignored inputs, then the exit state.
  task automatic hold_tail(input logic [2:0] sl, input logic [2:0] sr, input logic to_mo, input logic [1:0] mw);
    for (int k = 1; k <= 4; k++)
      add(1'b0, (k == 1), (k == 2), 1'b0, (k == 3), (k == 4), mk(S_RO, 2'd0, sl, sr, 1'b0, 2'b00), "hold");
    if (to_mo)
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(S_MO, 2'd0, sl, sr, 1'b0, mw), "to_mo");
    else
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(S_CD, 2'd3, sl, sr, 1'b0, 2'b00), "to_cd");
  endtask

  task automatic to_digit2(input logic [2:0] sl, input logic [2:0] sr);
    for (int k = 1; k <= 4; k++)
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(S_CD, (k == 4) ? 2'd2 : 2'd3, sl, sr, 1'b0, 2'b00), "to_d2");
  endtask

  // Drive one cycle, queue its expectation, compare after the edge.
  task automatic cyc(input in_t i, input out_t o, input logic [63:0] tag);
    out_t got, want;
    @(negedge clk);
    rst = i.rst; start = i.start; lp = i.lp; rp = i.rp; vl = i.vl; vr = i.vr;
    exp_q.push_back(o);
    @(posedge clk);
    #1;
    got = {state, countdown, score_left, score_right, round_done, match_winner, field_reset, play_en};
    want = exp_q.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %0s got st=%0d cd=%0d sl=%0d sr=%0d rd=%0b mw=%b fr=%0b pe=%0b want st=%0d cd=%0d sl=%0d sr=%0d rd=%0b mw=%b fr=%0b pe=%0b",
               tag, got.st, got.cd, got.sl, got.sr, got.rd, got.mw, got.fr, got.pe,
               want.st, want.cd, want.sl, want.sr, want.rd, want.mw, want.fr, want.pe);
    end
  endtask

  initial begin
    in_t  hi;
    out_t ho;
    // Reset and idle noise
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(S_IDLE, 2'd0, 3'd0, 3'd0, 1'b0, 2'b00), "reset");
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(S_IDLE, 2'd0, 3'd0, 3'd0, 1'b0, 2'b00), "reset");
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, mk(S_IDLE, 2'd0, 3'd0, 3'd0, 1'b0, 2'b00), "idle_ign");
    // Full countdown then PLAY; a press in PLAY does nothing
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(S_CD, 2'd3, 3'd0, 3'd0, 1'b0, 2'b00), "start");
    cd_tail(3'd0, 3'd0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk(S_PLAY, 2'd0, 3'd0, 3'd0, 1'b0, 2'b00), "play_prs");
    // Right wins a round
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(S_RO, 2'd0, 3'd0, 3'd1, 1'b1, 2'b00), "vic_r");
    hold_tail(3'd0, 3'd1, 1'b0, 2'b00);
    // Left false start at digit 2
    to_digit2(3'd0, 3'd1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(S_RO, 2'd0, 3'd0, 3'd2, 1'b1, 2'b00), "false_l");
    hold_tail(3'd0, 3'd2, 1'b0, 2'b00);
    // Simultaneous presses restart the countdown
    to_digit2(3'd0, 3'd2);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk(S_CD, 2'd3, 3'd0, 3'd2, 1'b0, 2'b00), "both_prs");
    cd_tail(3'd0, 3'd2);
    // Tie round
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, mk(S_RO, 2'd0, 3'd0, 3'd2, 1'b1, 2'b00), "tie");
    hold_tail(3'd0, 3'd2, 1'b0, 2'b00);
    cd_tail(3'd0, 3'd2);
    // Left takes three rounds
    for (int r = 1; r <= 3; r++) begin
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(S_RO, 2'd0, 3'(r), 3'd2, 1'b1, 2'b00), "vic_l");
      if (r < 3) begin
        hold_tail(3'(r), 3'd2, 1'b0, 2'b00);
        cd_tail(3'(r), 3'd2);
      end else begin
        hold_tail(3'd3, 3'd2, 1'b1, 2'b01);
      end
    end
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, mk(S_MO, 2'd0, 3'd3, 3'd2, 1'b0, 2'b01), "mo_hold");
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, mk(S_MO, 2'd0, 3'd3, 3'd2, 1'b0, 2'b01), "mo_hold");
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(S_CD, 2'd3, 3'd0, 3'd0, 1'b0, 2'b00), "restart");
    cd_tail(3'd0, 3'd0);
    // Build up score_left=2 in PLAY for the reset sequence
    for (int r = 1; r <= 2; r++) begin
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(S_RO, 2'd0, 3'(r), 3'd0, 1'b1, 2'b00), "vic_l2");
      hold_tail(3'(r), 3'd0, 1'b0, 2'b00);
      cd_tail(3'(r), 3'd0);
    end

    for (int n = 0; n < tbl.size(); n++)
      cyc(tbl[n].i, tbl[n].o, tbl[n].tag);

    // Reset mid-PLAY with start held high, then recovery
    hi = '0; hi.rst = 1'b1; hi.start = 1'b1;
    ho = mk(S_IDLE, 2'd0, 3'd0, 3'd0, 1'b0, 2'b00);
    cyc(hi, ho, "rst_play");
    cyc(hi, ho, "rst_start");
    hi = '0;
    cyc(hi, ho, "post_rst");
    hi.start = 1'b1;
    cyc(hi, mk(S_CD, 2'd3, 3'd0, 3'd0, 1'b0, 2'b00), "start2");

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got %0d leftover want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
